// File: rtl/rfid_pcd_rx_decoder_if.sv
// Decoded-byte valid/ready interface between the PCD receive decoder and its consumer.
interface rfid_pcd_rx_decoder_if;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in;
    logic [3:0] last_bits_out;

    modport master (output data_out, valid_out, last_bits_out, input ready_in);
    modport slave  (input data_out, valid_out, last_bits_out, output ready_in);
endinterface

// File: rtl/rfid_pcd_rx_decoder.sv
// ISO14443A PICC->PCD Manchester receiver: bit recovery, odd parity, byte handshake.
// Optional CRC_A residue check is enabled by defining RFID_RX_CRC_CHECK_EN.
//
// state       | meaning
// S_IDLE      | waiting for env_in rising edge with enable_in=1
// S_START     | sampling the start bit half pair
// S_DATA      | collecting data/parity bits, emitting bytes
// S_WAIT_IDLE | after a coding violation, wait for 2*HALF_BIT quiet cycles
module rfid_pcd_rx_decoder #(
    parameter int HALF_BIT  = 640,
    parameter int MAX_BYTES = 32
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       env_in,
    input  logic       enable_in,
    rfid_pcd_rx_decoder_if.master byte_if,
    output logic       busy_out,
    output logic       done_out,
    output logic [2:0] err_out,
    output logic [5:0] byte_cnt_out
`ifdef RFID_RX_CRC_CHECK_EN
    ,
    output logic       crc_ok_out
`endif
);

    localparam int TW = 13;
    localparam logic [TW-1:0] T_QTR  = TW'(HALF_BIT / 2 - 1);
    localparam logic [TW-1:0] T_HALF = TW'(HALF_BIT - 1);
    localparam logic [TW-1:0] T_QUIET = TW'(2 * HALF_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_WAIT_IDLE} state_t;

    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic            phase_q;
    logic            a_q;
    logic            env_prev_q;
    logic [3:0]      bit_cnt_q;
    logic [7:0]      shreg_q;
    logic [7:0]      frm_bytes_q;
    logic [7:0]      data_q;
    logic            valid_q;
    logic [3:0]      last_bits_q;
    logic            done_q;
    logic [2:0]      err_q;
    logic [5:0]      byte_cnt_q;

    logic            tick_d;
    logic            sample_b_d;
    logic            is_bit_d;
    logic            bit_val_d;
    logic            eof_d;
    logic            viol_d;
    logic            in_data_d;
    logic            emit_d;
    logic [3:0]      emit_bits_d;

`ifdef RFID_RX_CRC_CHECK_EN
    logic [15:0]     crc_q;
    logic            crc_ok_q;

    function automatic logic [15:0] crc_a_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction

    assign crc_ok_out = crc_ok_q;
`endif

    always_comb begin
        tick_d      = (timer_q == '0);
        sample_b_d  = tick_d && phase_q;
        is_bit_d    = a_q ^ env_in;
        bit_val_d   = a_q;
        eof_d       = !a_q && !env_in;
        // A new byte beyond MAX_BYTES aborts the frame like a bad half pair.
        viol_d      = (a_q && env_in) ||
                      (is_bit_d && bit_cnt_q == 4'd0 && int'(frm_bytes_q) >= MAX_BYTES);
        in_data_d   = enable_in && state_q == S_DATA && sample_b_d;
        emit_d      = 1'b0;
        emit_bits_d = 4'd8;
        if (in_data_d && !viol_d) begin
            if (eof_d && bit_cnt_q != 4'd0) begin
                emit_d      = 1'b1;
                emit_bits_d = bit_cnt_q;
            end else if (is_bit_d && bit_cnt_q == 4'd8) begin
                emit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            phase_q     <= 1'b0;
            a_q         <= 1'b0;
            env_prev_q  <= 1'b0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            frm_bytes_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_bits_q <= '0;
            done_q      <= 1'b0;
            err_q       <= '0;
            byte_cnt_q  <= '0;
`ifdef RFID_RX_CRC_CHECK_EN
            crc_q       <= 16'h6363;
            crc_ok_q    <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
            env_prev_q <= env_in;

            if (valid_q && byte_if.ready_in) begin
                valid_q <= 1'b0;
            end
            if (emit_d) begin
                if (valid_q && !byte_if.ready_in) begin
                    err_q[2] <= 1'b1;
                end else begin
                    data_q      <= shreg_q;
                    last_bits_q <= emit_bits_d;
                    valid_q     <= 1'b1;
                    if (byte_cnt_q != 6'd63) begin
                        byte_cnt_q <= byte_cnt_q + 6'd1;
                    end
                end
            end

            if (!enable_in) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (env_in && !env_prev_q) begin
                            state_q     <= S_START;
                            timer_q     <= T_QTR;
                            phase_q     <= 1'b0;
                            bit_cnt_q   <= '0;
                            shreg_q     <= '0;
                            frm_bytes_q <= '0;
                            err_q       <= '0;
                            byte_cnt_q  <= '0;
`ifdef RFID_RX_CRC_CHECK_EN
                            crc_q       <= 16'h6363;
                            crc_ok_q    <= 1'b0;
`endif
                        end
                    end
                    S_START, S_DATA: begin
                        if (!tick_d) begin
                            timer_q <= timer_q - TW'(1);
                        end else if (!phase_q) begin
                            a_q     <= env_in;
                            phase_q <= 1'b1;
                            timer_q <= T_HALF;
                        end else begin
                            phase_q <= 1'b0;
                            timer_q <= T_HALF;
                            if (state_q == S_START) begin
                                state_q <= (is_bit_d && bit_val_d) ? S_DATA : S_IDLE;
                            end else if (viol_d) begin
                                err_q[1] <= 1'b1;
                                done_q   <= 1'b1;
                                state_q  <= S_WAIT_IDLE;
                                timer_q  <= T_QUIET;
                            end else if (eof_d) begin
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
`ifdef RFID_RX_CRC_CHECK_EN
                                crc_ok_q <= (bit_cnt_q == 4'd0) && (crc_q == 16'h0000) &&
                                            (byte_cnt_q >= 6'd3);
`endif
                            end else if (bit_cnt_q != 4'd8) begin
                                shreg_q[bit_cnt_q[2:0]] <= bit_val_d;
                                bit_cnt_q               <= bit_cnt_q + 4'd1;
                            end else begin
                                // Odd parity: data bits plus parity bit must XOR to 1.
                                if (!(^shreg_q ^ bit_val_d)) begin
                                    err_q[0] <= 1'b1;
                                end
                                bit_cnt_q <= '0;
                                shreg_q   <= '0;
                                if (frm_bytes_q != 8'hFF) begin
                                    frm_bytes_q <= frm_bytes_q + 8'd1;
                                end
`ifdef RFID_RX_CRC_CHECK_EN
                                crc_q <= crc_a_upd(crc_q, shreg_q);
`endif
                            end
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (env_in) begin
                            timer_q <= T_QUIET;
                        end else if (tick_d) begin
                            state_q <= S_IDLE;
                        end else begin
                            timer_q <= timer_q - TW'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign byte_if.data_out      = data_q;
    assign byte_if.valid_out     = valid_q;
    assign byte_if.last_bits_out = last_bits_q;
    assign busy_out              = (state_q != S_IDLE);
    assign done_out              = done_q;
    assign err_out               = err_q;
    assign byte_cnt_out          = byte_cnt_q;

endmodule

// File: tb/tb_rfid_pcd_rx_decoder.sv
// Randomized and directed bench for rfid_pcd_rx_decoder with a frame-level reference model.
module tb_rfid_pcd_rx_decoder;
    localparam int H = 8;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       env_in;
    logic       enable_in;
    logic       busy_out;
    logic       done_out;
    logic [2:0] err_out;
    logic [5:0] byte_cnt_out;
`ifdef RFID_RX_CRC_CHECK_EN
    logic       crc_ok_out;
`endif

    rfid_pcd_rx_decoder_if bif();

    rfid_pcd_rx_decoder #(.HALF_BIT(H), .MAX_BYTES(32)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .env_in       (env_in),
        .enable_in    (enable_in),
        .byte_if      (bif),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .err_out      (err_out),
        .byte_cnt_out (byte_cnt_out)
`ifdef RFID_RX_CRC_CHECK_EN
        ,
        .crc_ok_out   (crc_ok_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor: handshakes and done pulses, sampled on the falling edge.
    logic [11:0] obs_q[$];
    int   done_cnt;
    int   done_cyc;
    logic done_valid;
    logic done_rise;
    logic prev_valid = 1'b0;
    always @(negedge clk_in) begin
        if (bif.valid_out && bif.ready_in) obs_q.push_back({bif.last_bits_out, bif.data_out});
        if (done_out) begin
            done_cnt++;
            done_cyc   = cyc;
            done_valid = bif.valid_out;
            done_rise  = bif.valid_out & ~prev_valid;
        end
        prev_valid = bif.valid_out;
    end

    // Symbol stream: 1/0 = Manchester bit, 2 = EOF (both halves low), 3 = both halves high.
    int syms[$];
    int t0edge;

    function automatic logic lvl(input int sym, input int j);
        case (sym)
            1:       return j < H;
            0:       return j >= H;
            2:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic drive_level(input logic lv, input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1 env_in = lv;
        end
    endtask

    task automatic send();
        bit first = 1'b1;
        foreach (syms[i]) begin
            for (int j = 0; j < 2 * H; j++) begin
                @(posedge clk_in);
                #1;
                if (first) begin
                    t0edge = cyc + 1;
                    first  = 1'b0;
                end
                env_in = lvl(syms[i], j);
            end
        end
    endtask

    task automatic add_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) syms.push_back(int'(v[i]));
    endtask

    task automatic add_byte(input logic [7:0] v, input bit bad);
        add_bits(v, 8);
        syms.push_back(bad ? int'(^v) : int'(~^v));
    endtask

    task automatic run_frame(input int settle);
        obs_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        drive_level(1'b0, H);
        send();
        drive_level(1'b0, settle);
        @(negedge clk_in);
    endtask

    function automatic int exp_done_cyc(input int keof);
        return t0edge + keof * 2 * H + H / 2 + H;
    endfunction

    logic [11:0] exp_q[$];
    logic [2:0]  exp_err;

    task automatic cmp_frame(input string tag);
        chk({tag, "_nbytes"}, obs_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) chk({tag, "_byte"}, obs_q[i], exp_q[i]);
        end
        chk({tag, "_err"}, err_out, exp_err);
        chk({tag, "_bcnt"}, byte_cnt_out, exp_q.size());
        chk({tag, "_done_n"}, done_cnt, 1);
        chk({tag, "_done_t"}, done_cyc, exp_done_cyc(syms.size() - 1));
        chk({tag, "_busy"}, busy_out, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] frame4[4];
        rst_in        = 1'b1;
        env_in        = 1'b0;
        enable_in     = 1'b0;
        bif.ready_in  = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_valid", bif.valid_out, 0);
        chk("rst_data", bif.data_out, 0);
        chk("rst_last", bif.last_bits_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_err", err_out, 0);
        chk("rst_bcnt", byte_cnt_out, 0);
        #1 rst_in = 1'b0;
        enable_in = 1'b1;
        drive_level(1'b0, 4);

        // Single byte 0x35
        syms = {1};
        add_byte(8'h35, 1'b0);
        syms.push_back(2);
        exp_q = {{4'd8, 8'h35}};
        exp_err = 3'b000;
        run_frame(4 * H);
        cmp_frame("one_byte");

        // Four bytes
        frame4 = '{8'h24, 8'h90, 8'h67, 8'h35};
        syms = {1};
        exp_q.delete();
        foreach (frame4[i]) begin
            add_byte(frame4[i], 1'b0);
            exp_q.push_back({4'd8, frame4[i]});
        end
        syms.push_back(2);
        run_frame(4 * H);
        cmp_frame("four_bytes");

        // Bad parity
        syms = {1};
        add_byte(8'h35, 1'b1);
        syms.push_back(2);
        exp_q = {{4'd8, 8'h35}};
        exp_err = 3'b001;
        run_frame(4 * H);
        cmp_frame("bad_par");

        // Partial 4-bit frame 0b0100
        syms = {1};
        add_bits(8'h04, 4);
        syms.push_back(2);
        exp_q = {{4'd4, 8'h04}};
        exp_err = 3'b000;
        run_frame(4 * H);
        cmp_frame("partial");
        chk("partial_valid_at_done", done_valid, 1);
        chk("partial_valid_rise_at_done", done_rise, 1);

        // Coding violation in bit 3, envelope then held high
        syms = {1, 0, 0, 1, 3};
        obs_q.delete();
        done_cnt = 0;
        drive_level(1'b0, H);
        send();
        drive_level(1'b1, 3 * H);
        chk("viol_busy_high", busy_out, 1);
        drive_level(1'b0, 10);
        @(negedge clk_in);
        chk("viol_busy_wait", busy_out, 1);
        drive_level(1'b0, 10);
        @(negedge clk_in);
        chk("viol_busy_end", busy_out, 0);
        chk("viol_err", err_out, 3'b010);
        chk("viol_nbytes", obs_q.size(), 0);
        chk("viol_done_n", done_cnt, 1);

        // Overrun: ready held low across two bytes
        #1 bif.ready_in = 1'b0;
        syms = {1};
        add_byte(8'h11, 1'b0);
        add_byte(8'h22, 1'b0);
        syms.push_back(2);
        run_frame(4 * H);
        chk("ovr_data_held", bif.data_out, 8'h11);
        chk("ovr_valid_held", bif.valid_out, 1);
        chk("ovr_err", err_out, 3'b100);
        chk("ovr_done_n", done_cnt, 1);
        @(posedge clk_in);
        #1 bif.ready_in = 1'b1;
        drive_level(1'b0, 3);
        @(negedge clk_in);
        chk("ovr_nbytes", obs_q.size(), 1);
        if (obs_q.size() > 0) chk("ovr_byte", obs_q[0], {4'd8, 8'h11});
        chk("ovr_valid_clr", bif.valid_out, 0);

        // enable_in dropped mid-frame
        syms = {1, 1, 0, 1};
        obs_q.delete();
        done_cnt = 0;
        drive_level(1'b0, H);
        send();
        @(posedge clk_in);
        #1 enable_in = 1'b0;
        env_in = 1'b0;
        drive_level(1'b0, 2);
        @(negedge clk_in);
        chk("dis_busy", busy_out, 0);
        chk("dis_done_n", done_cnt, 0);
        #1 enable_in = 1'b1;

        // Short glitch rejected silently; errors cleared at the start
        obs_q.delete();
        done_cnt = 0;
        drive_level(1'b0, H);
        drive_level(1'b1, 2);
        drive_level(1'b0, 4 * H);
        @(negedge clk_in);
        chk("glitch_done_n", done_cnt, 0);
        chk("glitch_busy", busy_out, 0);
        chk("glitch_err", err_out, 0);
        chk("glitch_nbytes", obs_q.size(), 0);

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            int nb;
            int np;
            nb = $urandom_range(1, 4);
            np = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            syms = {1};
            exp_q.delete();
            exp_err = 3'b000;
            for (int b = 0; b < nb; b++) begin
                bit bad;
                d   = 8'($urandom);
                bad = ($urandom_range(0, 3) == 0);
                add_byte(d, bad);
                exp_q.push_back({4'd8, d});
                if (bad) exp_err[0] = 1'b1;
            end
            if (np != 0) begin
                d = 8'($urandom_range(0, (1 << np) - 1));
                add_bits(d, np);
                exp_q.push_back({4'(np), d});
            end
            syms.push_back(2);
            run_frame($urandom_range(3 * H, 6 * H));
            cmp_frame("rand");
        end

`ifdef RFID_RX_CRC_CHECK_EN
        frame4 = '{8'h00, 8'h00, 8'hA0, 8'h1E};
        syms = {1};
        foreach (frame4[i]) add_byte(frame4[i], 1'b0);
        syms.push_back(2);
        run_frame(4 * H);
        chk("crc_good", crc_ok_out, 1);
        frame4[3] = 8'h1F;
        syms = {1};
        foreach (frame4[i]) add_byte(frame4[i], 1'b0);
        syms.push_back(2);
        run_frame(4 * H);
        chk("crc_bad", crc_ok_out, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
